// File: rtl/dec_scan_sequencer_if.sv
// Select/enable bus between the scan sequencer and its controller, plus the
// decoder-facing outputs. The master drives requests; the slave is the sequencer.
interface dec_scan_sequencer_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  logic               scan_en;
  logic [DWELL_W-1:0] dwell;
  logic               req_valid;
  logic [SEL_W-1:0]   req_sel;
  logic               req_ready;
  logic [SEL_W-1:0]   sel;
  logic               enable;
  logic               busy;
  logic               wrap;

  modport master (
    output scan_en, dwell, req_valid, req_sel,
    input  req_ready, sel, enable, busy, wrap
  );

  modport slave (
    input  scan_en, dwell, req_valid, req_sel,
    output req_ready, sel, enable, busy, wrap
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Drives a 3-to-8 decoder's select/enable: auto-scan over all slots with a
// programmable dwell, or single-shot addressing of one slot via valid/ready.
module dec_scan_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dec_scan_sequencer_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOT = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_en;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic               w_accept;

  // Ready is masked by rst so nothing is handshaken during a reset cycle.
  assign bus.req_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign bus.sel    = r_sel;
  assign bus.enable = r_en;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.wrap   = r_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SHOT;
            r_sel   <= bus.req_sel;
            r_en    <= 1'b1;
            r_cnt   <= bus.dwell;
          end else if (bus.scan_en) begin
            r_state <= S_SCAN;
            r_sel   <= '0;
            r_en    <= 1'b1;
            r_cnt   <= bus.dwell;
          end else begin
            r_en <= 1'b0;
          end
        end
        S_SHOT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Slot end: scan_en is only honoured here, so slots are never cut short.
            if (r_sel == SEL_MAX) r_wrap <= 1'b1;
            if (!bus.scan_en) begin
              r_state <= S_IDLE;
              r_en    <= 1'b0;
            end else begin
              r_sel <= r_sel + 1'b1;
              r_cnt <= bus.dwell;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Directed bench for dec_scan_sequencer: table of single-cycle vectors for
// reset/shot/priority, then hand-written scan, stop, ignore and mid-op reset runs.
module tb_dec_scan_sequencer;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  dec_scan_sequencer_if #(.SEL_W(3), .DWELL_W(8)) bus ();

  dec_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       scan_en;
    logic [7:0] dwell;
    logic       rv;
    logic [2:0] rs;
    logic [2:0] esel;
    logic       een;
    logic       ebusy;
    logic       ewrap;
    logic       erdy;
  } vec_t;

  vec_t tv [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int esel, input int een,
                         input int ebusy, input int ewrap, input int erdy);
    chk({nm, ".sel"},   int'(bus.sel),       esel);
    chk({nm, ".en"},    int'(bus.enable),    een);
    chk({nm, ".busy"},  int'(bus.busy),      ebusy);
    chk({nm, ".wrap"},  int'(bus.wrap),      ewrap);
    chk({nm, ".ready"}, int'(bus.req_ready), erdy);
  endtask

  initial begin
    rst = 1'b1; bus.scan_en = 1'b1; bus.dwell = 8'd3; bus.req_valid = 1'b1; bus.req_sel = 3'd2;

    //           rst   scan  dwell  rv    rs     esel  en    busy  wrap  rdy
    tv[0]  = '{1'b1, 1'b1, 8'd3, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 8'd3, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 8'd3, 1'b1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 8'd0, 1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b0, 8'd1, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 8'd1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 8'd1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; bus.scan_en = tv[i].scan_en; bus.dwell = tv[i].dwell;
      bus.req_valid = tv[i].rv; bus.req_sel = tv[i].rs;
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].esel, tv[i].een, tv[i].ebusy, tv[i].ewrap, tv[i].erdy);
    end

    // Scan with dwell=1; a request pulse mid-scan must be ignored.
    bus.dwell = 8'd1; bus.scan_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = (i == 5); bus.req_sel = 3'd6;
      tick();
      chk_all($sformatf("scan1_%0d", i), i / 2, 1, 1, 0, 0);
    end
    bus.req_valid = 1'b0;
    tick(); chk_all("scan1_wrap", 0, 1, 1, 1, 0);
    bus.scan_en = 1'b0;
    tick(); chk_all("scan1_after", 0, 1, 1, 0, 0);
    tick(); chk_all("scan1_stop", 0, 0, 0, 0, 1);

    // dwell=0: one cycle per slot, enable continuously high.
    bus.dwell = 8'd0; bus.scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); chk_all($sformatf("scan0_%0d", i), i, 1, 1, 0, 0);
    end
    tick(); chk_all("scan0_wrap", 0, 1, 1, 1, 0);
    bus.scan_en = 1'b0;
    tick(); chk_all("scan0_stop", 0, 0, 0, 0, 1);

    // Stop request mid-slot: slot 3 still runs its full 3 cycles.
    bus.dwell = 8'd2; bus.scan_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick(); chk_all($sformatf("stop_%0d", t), t / 3, 1, 1, 0, 0);
    end
    bus.scan_en = 1'b0;
    tick(); chk_all("stop_10", 3, 1, 1, 0, 0);
    tick(); chk_all("stop_11", 3, 1, 1, 0, 0);
    tick(); chk_all("stop_end", 3, 0, 0, 0, 1);

    // Reset in the middle of slot 4, then restart from slot 0 with full dwell.
    bus.scan_en = 1'b1;
    for (int t = 0; t < 13; t++) begin
      tick(); chk_all($sformatf("mrst_%0d", t), t / 3, 1, 1, 0, 0);
    end
    rst = 1'b1;
    tick(); chk_all("mrst_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(); chk_all($sformatf("mrst_re%0d", t), t / 3, 1, 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
